// File: rtl/mod_n_updown_counter_pkg.sv
// Shared clock-chain constants and the step-direction encoding
// used by the modulo-N up/down counter and its step logic.
package mod_n_updown_counter_pkg;

  localparam int unsigned SEC_MODULUS  = 60;
  localparam int unsigned MIN_MODULUS  = 60;
  localparam int unsigned HOUR_MODULUS = 24;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_e;

  function automatic step_e step_dir(
    input logic en,
    input logic up,
    input logic down
  );
    step_e d;
    d = STEP_HOLD;
    unique case (1'b1)
      (en & up & ~down): d = STEP_UP;
      (en & down & ~up): d = STEP_DOWN;
      default:           d = STEP_HOLD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mod_n_step.sv
// Combinational next-count for one step in either direction:
// increment/decrement with wrap, plus recovery of out-of-range counts.
module mod_n_step
  import mod_n_updown_counter_pkg::*;
#(
  parameter int unsigned MODULUS = 60,
  parameter int unsigned WIDTH   = $clog2(MODULUS)
) (
  input  logic [WIDTH-1:0] count,
  input  step_e            dir,
  output logic [WIDTH-1:0] next
);

  localparam int unsigned EW = WIDTH + 1;
  localparam logic [WIDTH:0] LAST = EW'(MODULUS - 1);

  logic [WIDTH:0] cur;

  assign cur = {1'b0, count};

  // One extra bit keeps the +1/-1 and range compares free of aliasing
  always_comb begin
    next = count;
    unique case (dir)
      STEP_UP: begin
        if (cur >= LAST) next = '0;
        else             next = WIDTH'(cur + 1'b1);
      end
      STEP_DOWN: begin
        if (cur > LAST)       next = '0;
        else if (cur == '0)   next = WIDTH'(LAST);
        else                  next = WIDTH'(cur - 1'b1);
      end
      default: next = count;
    endcase
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Cascadable modulo-N up/down counter with clear, clamped load,
// combinational carry/borrow strobes and registered wrap/error pulses.
module mod_n_updown_counter
  import mod_n_updown_counter_pkg::*;
#(
  parameter int unsigned MODULUS   = 60,
  parameter int unsigned WIDTH     = $clog2(MODULUS),
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_cin,
  input  logic             i_up,
  input  logic             i_down,
  output logic [WIDTH-1:0] o_count,
  output logic             o_carryup,
  output logic             o_borrowdown,
  output logic             o_wrap,
  output logic             o_load_err
);

  localparam int unsigned EW = WIDTH + 1;
  localparam logic [WIDTH:0] LAST = EW'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

  logic             step_en;
  step_e            dir;
  logic [WIDTH-1:0] step_next;
  logic             load_oor;
  logic [WIDTH-1:0] count_d;

  assign step_en  = i_cin & ~i_clr & ~i_load;
  assign dir      = step_dir(step_en, i_up, i_down);
  assign load_oor = ({1'b0, i_load_val} > LAST);

  assign o_carryup    = (dir == STEP_UP) &&
                        ({1'b0, o_count} == LAST);
  assign o_borrowdown = (dir == STEP_DOWN) &&
                        (o_count == '0);

  mod_n_step #(
    .MODULUS (MODULUS),
    .WIDTH   (WIDTH)
  ) u_step (
    .count (o_count),
    .dir   (dir),
    .next  (step_next)
  );

  // Clear beats load beats step; bad loads clamp to the top value
  always_comb begin
    count_d = step_next;
    if (i_clr)
      count_d = '0;
    else if (i_load)
      count_d = load_oor ? WIDTH'(LAST) : i_load_val;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_count    <= RST_CNT;
      o_wrap     <= 1'b0;
      o_load_err <= 1'b0;
    end else begin
      o_count    <= count_d;
      o_wrap     <= o_carryup | o_borrowdown;
      o_load_err <= i_load & ~i_clr & load_oor;
    end
  end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Bench for the modulo-N counter: a 60 stage and a 24 stage that can
// be cascaded; expectations are queued with stimulus, popped at check.
module tb_mod_n_updown_counter;
  import mod_n_updown_counter_pkg::*;

  typedef struct {
    int cnt;
    bit wrap;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;

  logic       lo_clr = 0, lo_load = 0, lo_cin = 0;
  logic       lo_up = 0, lo_down = 0;
  logic [5:0] lo_load_val = '0;
  logic [5:0] lo_count;
  logic       lo_cu, lo_bd, lo_wrap, lo_err;

  logic       hi_clr = 0, hi_load = 0;
  logic       hi_cin_tb = 0, hi_up_tb = 0, hi_down_tb = 0;
  logic [4:0] hi_load_val = '0;
  logic       hi_cin, hi_up, hi_down;
  logic [4:0] hi_count;
  logic       hi_cu, hi_bd, hi_wrap, hi_err;

  logic casc = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];
  bit   sq[$];

  always #5 clk = ~clk;

  assign hi_cin  = casc ? (lo_cu | lo_bd) : hi_cin_tb;
  assign hi_up   = casc ? lo_cu : hi_up_tb;
  assign hi_down = casc ? lo_bd : hi_down_tb;

  mod_n_updown_counter #(
    .MODULUS (SEC_MODULUS),
    .WIDTH   (6),
    .RESET_VAL (0)
  ) u_lo (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_clr        (lo_clr),
    .i_load       (lo_load),
    .i_load_val   (lo_load_val),
    .i_cin        (lo_cin),
    .i_up         (lo_up),
    .i_down       (lo_down),
    .o_count      (lo_count),
    .o_carryup    (lo_cu),
    .o_borrowdown (lo_bd),
    .o_wrap       (lo_wrap),
    .o_load_err   (lo_err)
  );

  mod_n_updown_counter #(
    .MODULUS (HOUR_MODULUS),
    .WIDTH   (5),
    .RESET_VAL (12)
  ) u_hi (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_clr        (hi_clr),
    .i_load       (hi_load),
    .i_load_val   (hi_load_val),
    .i_cin        (hi_cin),
    .i_up         (hi_up),
    .i_down       (hi_down),
    .o_count      (hi_count),
    .o_carryup    (hi_cu),
    .o_borrowdown (hi_bd),
    .o_wrap       (hi_wrap),
    .o_load_err   (hi_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    lo_clr = 0; lo_load = 0; lo_cin = 0;
    lo_up = 0; lo_down = 0;
    hi_clr = 0; hi_load = 0; hi_cin_tb = 0;
    hi_up_tb = 0; hi_down_tb = 0;
    casc = 0;
  endtask

  task automatic test_reset;
    exp_t e;
    bit s;
    idle();
    #2 rstn = 1'b0;
    q.push_back('{0, 0, 0});
    q.push_back('{12, 0, 0});
    sq.push_back(0);
    sq.push_back(0);
    #1;
    e = q.pop_front();
    n_cmp++;
    if (lo_count !== e.cnt) begin
      n_bad++;
      $display("FAIL rst_lo_count got %0d want %0d", lo_count, e.cnt);
    end
    n_cmp++;
    if (lo_wrap !== e.wrap || lo_err !== e.err) begin
      n_bad++;
      $display("FAIL rst_lo_flags got %0b%0b want %0b%0b",
               lo_wrap, lo_err, e.wrap, e.err);
    end
    e = q.pop_front();
    n_cmp++;
    if (hi_count !== e.cnt) begin
      n_bad++;
      $display("FAIL rst_hi_count got %0d want %0d", hi_count, e.cnt);
    end
    s = sq.pop_front();
    n_cmp++;
    if (lo_cu !== s) begin
      n_bad++;
      $display("FAIL rst_lo_carry got %0b want %0b", lo_cu, s);
    end
    s = sq.pop_front();
    n_cmp++;
    if (hi_bd !== s) begin
      n_bad++;
      $display("FAIL rst_hi_borrow got %0b want %0b", hi_bd, s);
    end
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_carry_up;
    exp_t e;
    bit s;
    lo_load = 1; lo_load_val = 6'd59;
    tick();
    lo_load = 0; lo_cin = 1; lo_up = 1;
    sq.push_back(1);
    #1;
    s = sq.pop_front();
    n_cmp++;
    if (lo_cu !== s) begin
      n_bad++;
      $display("FAIL up59_carry got %0b want %0b", lo_cu, s);
    end
    q.push_back('{0, 1, 0});
    tick();
    e = q.pop_front();
    n_cmp++;
    if (lo_count !== e.cnt || lo_wrap !== e.wrap) begin
      n_bad++;
      $display("FAIL up59_wrap got %0d/%0b want %0d/%0b",
               lo_count, lo_wrap, e.cnt, e.wrap);
    end
    lo_up = 0;
    q.push_back('{0, 0, 0});
    tick();
    e = q.pop_front();
    n_cmp++;
    if (lo_count !== e.cnt || lo_wrap !== e.wrap) begin
      n_bad++;
      $display("FAIL up59_after got %0d/%0b want %0d/%0b",
               lo_count, lo_wrap, e.cnt, e.wrap);
    end
    idle();
  endtask

  task automatic test_borrow_down;
    exp_t e;
    bit s;
    hi_clr = 1;
    tick();
    hi_clr = 0; hi_cin_tb = 1; hi_down_tb = 1;
    sq.push_back(1);
    #1;
    s = sq.pop_front();
    n_cmp++;
    if (hi_bd !== s) begin
      n_bad++;
      $display("FAIL dn0_borrow got %0b want %0b", hi_bd, s);
    end
    q.push_back('{23, 1, 0});
    tick();
    e = q.pop_front();
    n_cmp++;
    if (hi_count !== e.cnt || hi_wrap !== e.wrap) begin
      n_bad++;
      $display("FAIL dn0_wrap got %0d/%0b want %0d/%0b",
               hi_count, hi_wrap, e.cnt, e.wrap);
    end
    hi_down_tb = 0;
    q.push_back('{23, 0, 0});
    tick();
    e = q.pop_front();
    n_cmp++;
    if (hi_count !== e.cnt || hi_wrap !== e.wrap) begin
      n_bad++;
      $display("FAIL dn0_after got %0d/%0b want %0d/%0b",
               hi_count, hi_wrap, e.cnt, e.wrap);
    end
    idle();
  endtask

  task automatic test_load_err;
    exp_t e;
    int vals[3] = '{63, 30, 30};
    bit lds[3] = '{1, 1, 0};
    q.push_back('{59, 0, 1});
    q.push_back('{30, 0, 0});
    q.push_back('{30, 0, 0});
    for (int i = 0; i < 3; i++) begin
      lo_load = lds[i];
      lo_load_val = 6'(vals[i]);
      tick();
      e = q.pop_front();
      n_cmp++;
      if (lo_count !== e.cnt || lo_err !== e.err) begin
        n_bad++;
        $display("FAIL load_%0d got %0d/%0b want %0d/%0b",
                 i, lo_count, lo_err, e.cnt, e.err);
      end
    end
    idle();
  endtask

  task automatic test_priority;
    exp_t e;
    bit s;
    lo_load = 1; lo_load_val = 6'd59;
    tick();
    lo_clr = 1; lo_load_val = 6'd63;
    lo_cin = 1; lo_up = 1;
    sq.push_back(0);
    #1;
    s = sq.pop_front();
    n_cmp++;
    if (lo_cu !== s) begin
      n_bad++;
      $display("FAIL prio_carry got %0b want %0b", lo_cu, s);
    end
    q.push_back('{0, 0, 0});
    tick();
    e = q.pop_front();
    n_cmp++;
    if (lo_count !== e.cnt || lo_wrap !== e.wrap ||
        lo_err !== e.err) begin
      n_bad++;
      $display("FAIL prio_clr got %0d/%0b/%0b want %0d/%0b/%0b",
               lo_count, lo_wrap, lo_err, e.cnt, e.wrap, e.err);
    end
    idle();
  endtask

  task automatic test_hold;
    exp_t e;
    bit cins[4] = '{1, 0, 1, 1};
    bit ups[4]  = '{1, 1, 1, 0};
    bit dns[4]  = '{1, 0, 0, 1};
    lo_load = 1; lo_load_val = 6'd17;
    tick();
    lo_load = 0;
    q.push_back('{17, 0, 0});
    q.push_back('{17, 0, 0});
    q.push_back('{18, 0, 0});
    q.push_back('{17, 0, 0});
    for (int i = 0; i < 4; i++) begin
      lo_cin = cins[i]; lo_up = ups[i]; lo_down = dns[i];
      tick();
      e = q.pop_front();
      n_cmp++;
      if (lo_count !== e.cnt || lo_wrap !== e.wrap) begin
        n_bad++;
        $display("FAIL hold_%0d got %0d/%0b want %0d/%0b",
                 i, lo_count, lo_wrap, e.cnt, e.wrap);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back;
    exp_t e;
    lo_clr = 1;
    tick();
    lo_clr = 0; lo_cin = 1; lo_down = 1;
    q.push_back('{59, 1, 0});
    q.push_back('{58, 0, 0});
    q.push_back('{57, 0, 0});
    for (int i = 0; i < 3; i++) begin
      tick();
      e = q.pop_front();
      n_cmp++;
      if (lo_count !== e.cnt || lo_wrap !== e.wrap) begin
        n_bad++;
        $display("FAIL b2b_dn_%0d got %0d/%0b want %0d/%0b",
                 i, lo_count, lo_wrap, e.cnt, e.wrap);
      end
    end
    idle();
  endtask

  task automatic test_cascade;
    exp_t e;
    exp_t f;
    bit s;
    lo_load = 1; lo_load_val = 6'd59;
    hi_load = 1; hi_load_val = 5'd23;
    tick();
    lo_load = 0; hi_load = 0;
    casc = 1; lo_cin = 1; lo_up = 1;
    sq.push_back(1);
    #1;
    s = sq.pop_front();
    n_cmp++;
    if (hi_cu !== s) begin
      n_bad++;
      $display("FAIL casc_carry got %0b want %0b", hi_cu, s);
    end
    q.push_back('{0, 1, 0});
    q.push_back('{0, 1, 0});
    q.push_back('{1, 0, 0});
    q.push_back('{0, 0, 0});
    for (int i = 0; i < 2; i++) begin
      tick();
      e = q.pop_front();
      f = q.pop_front();
      n_cmp++;
      if (lo_count !== e.cnt || lo_wrap !== e.wrap ||
          hi_count !== f.cnt || hi_wrap !== f.wrap) begin
        n_bad++;
        $display("FAIL casc_%0d got %0d:%0d w%0b%0b want %0d:%0d w%0b%0b",
                 i, hi_count, lo_count, hi_wrap, lo_wrap,
                 f.cnt, e.cnt, f.wrap, e.wrap);
      end
    end
    #3 rstn = 1'b0;
    q.push_back('{0, 0, 0});
    q.push_back('{12, 0, 0});
    #1;
    e = q.pop_front();
    f = q.pop_front();
    n_cmp++;
    if (lo_count !== e.cnt || hi_count !== f.cnt ||
        lo_wrap !== e.wrap || hi_wrap !== f.wrap) begin
      n_bad++;
      $display("FAIL casc_rst got %0d:%0d want %0d:%0d",
               hi_count, lo_count, f.cnt, e.cnt);
    end
    q.push_back('{0, 0, 0});
    q.push_back('{12, 0, 0});
    tick();
    e = q.pop_front();
    f = q.pop_front();
    n_cmp++;
    if (lo_count !== e.cnt || hi_count !== f.cnt) begin
      n_bad++;
      $display("FAIL casc_rst_hold got %0d:%0d want %0d:%0d",
               hi_count, lo_count, f.cnt, e.cnt);
    end
    idle();
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_carry_up();
    test_borrow_down();
    test_load_err();
    test_priority();
    test_hold();
    test_back_to_back();
    test_cascade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_n_updown_counter.md
MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

Interface
REQ-001 The block SHALL have parameter MODULUS, default 60, giving the count range 0..MODULUS-1; legal range 2..65536.
REQ-002 The block SHALL have parameter WIDTH, default $clog2(MODULUS), giving the count width in bits.
REQ-003 The block SHALL have parameter RESET_VAL, default 0, giving the count value on reset; it SHALL be less than MODULUS.
REQ-004 The block SHALL have i_clk, input, 1 bit: clock, rising-edge active.
REQ-005 The block SHALL have i_rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have i_clr, input, 1 bit: synchronous clear to 0.
REQ-007 The block SHALL have i_load, input, 1 bit: synchronous load of i_load_val.
REQ-008 The block SHALL have i_load_val, input, WIDTH bits: value to load.
REQ-009 The block SHALL have i_cin, input, 1 bit: cascade enable; a step is allowed only while it is high.
REQ-010 The block SHALL have i_up, input, 1 bit: step request, count up.
REQ-011 The block SHALL have i_down, input, 1 bit: step request, count down.
REQ-012 The block SHALL have o_count, output, WIDTH bits: current registered count.
REQ-013 The block SHALL have o_carryup, output, 1 bit: combinational up-wrap strobe for the next stage's i_cin/i_up.
REQ-014 The block SHALL have o_borrowdown, output, 1 bit: combinational down-wrap strobe for the next stage's i_cin/i_down.
REQ-015 The block SHALL have o_wrap, output, 1 bit: registered one-cycle pulse after any wrap.
REQ-016 The block SHALL have o_load_err, output, 1 bit: registered one-cycle pulse after an out-of-range load.

Function
REQ-017 The block SHALL update state only on the rising edge of i_clk, with priority i_clr > i_load > step.
REQ-018 The block SHALL set the count to 0 when i_clr=1, regardless of all other inputs.
REQ-019 The block SHALL load i_load_val when i_load=1 and i_load_val<MODULUS.
REQ-020 The block SHALL load MODULUS-1 and pulse o_load_err on the next cycle when i_load=1 and i_load_val>=MODULUS.
REQ-021 The block SHALL perform an up step only when i_cin=1, i_up=1 and i_down=0: count+1, and MODULUS-1 wraps to 0.
REQ-022 The block SHALL perform a down step only when i_cin=1, i_up=0 and i_down=1: count-1, and 0 wraps to MODULUS-1.
REQ-023 The block SHALL hold the count when i_up=i_down, including 1/1, which is no longer a clear.
REQ-024 The block SHALL hold the count when i_cin=0.
REQ-025 The block SHALL drive o_carryup = i_cin & i_up & ~i_down & ~i_clr & ~i_load & (count==MODULUS-1), so a cascaded stage steps on the same edge.
REQ-026 The block SHALL drive o_borrowdown = i_cin & i_down & ~i_up & ~i_clr & ~i_load & (count==0).
REQ-027 The block SHALL register o_wrap as (o_carryup|o_borrowdown), so it is high exactly one cycle after the wrapping edge.
REQ-028 The block SHALL compute arithmetic at WIDTH+1 bits internally, and no intermediate value SHALL alias modulo 2^WIDTH when MODULUS is not a power of two.
REQ-029 The block SHALL correct any count value >= MODULUS (unreachable in normal operation) to 0 on the next step.

Reset
REQ-030 The block SHALL, while i_rstn=0, immediately force o_count=RESET_VAL, o_wrap=0 and o_load_err=0, independent of i_clk.
REQ-031 The block SHALL drive o_carryup and o_borrowdown to 0 during reset, which follows from the count value and gating.
REQ-032 The block SHALL, after i_rstn deassertion, act on the first rising i_clk edge with normal priority, and a reset asserted mid-step SHALL discard that step.

Structure
REQ-033 The shared clock package SHALL hold constants SEC_MODULUS=60, MIN_MODULUS=60 and HOUR_MODULUS=24 for instantiation.
REQ-034 The next-value logic (step/wrap/clamp, combinational) SHALL be in one sub-module, mod_n_step, and be reused by both step directions.
REQ-035 The block SHALL have no other hierarchy; stages cascade at the top level via o_carryup to i_cin.

Verification
REQ-036 The bench SHALL check, with MODULUS=60, count=59, i_cin=1, i_up=1: o_carryup=1 before the edge, count=0 after, and o_wrap=1 for one cycle.
REQ-037 The bench SHALL check, with MODULUS=24, count=0, i_down=1: o_borrowdown=1, count=23 after the edge, and o_wrap pulses.
REQ-038 The bench SHALL check that i_load=1 with i_load_val=63 (MODULUS=60) gives count=59 and o_load_err=1 for one cycle; a subsequent i_load_val=30 gives count=30 with no error.
REQ-039 The bench SHALL check that i_clr=1, i_load=1 and i_up=1 together at count=59 give count=0, o_carryup=0 and o_wrap=0.
REQ-040 The bench SHALL check that i_up=i_down=1 at count=17 holds 17, and that i_cin=0 with i_up=1 holds.
REQ-041 The bench SHALL check, on a two-stage cascade (60 then 24) with i_up held from 23:59, a transition to 00:00 on a single edge, and that i_rstn=0 asynchronously mid-cycle forces RESET_VAL on both stages.
